// File: rtl/mul_arb_if.sv
// Requester, response and shared-multiplier signals of the two-port multiply arbiter.
interface mul_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        mul_stall;
  logic [31:0] mul_opA;
  logic [31:0] mul_opB;
  logic [31:0] mul_result;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  rsp0_ready, rsp1_ready,
    output mul_stall, mul_opA, mul_opB,
    input  mul_result
  );

  // Requesters plus the multiplier itself.
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output rsp0_ready, rsp1_ready,
    input  mul_stall, mul_opA, mul_opB,
    output mul_result
  );
endinterface

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one 2-stage multiplier between two requesters.
// A 2-entry tag pipe follows the multiplier stages so each product is routed
// back to the requester that issued it.
module mul_arb (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  mul_arb_if.slave bus,
  output logic     busy
);

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  tag_t s1;
  tag_t s2;
  logic last_gnt;
  logic gnt_id;
  logic owner_ready;
  logic stall;
  logic issue_ok;
  logic accept;

  // Stall only for a real product in stage 2 whose owner cannot take it.
  always_comb begin
    owner_ready = s2.id ? bus.rsp1_ready : bus.rsp0_ready;
    stall       = rst_n && !flush && s2.valid && !owner_ready;
  end

  // Grant: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt_id   = (bus.req0_valid && bus.req1_valid) ? !last_gnt : bus.req1_valid;
    issue_ok = rst_n && !flush && !stall;
    accept   = issue_ok && (bus.req0_valid || bus.req1_valid);
  end

  // Drive handshakes, multiplier operands and response routing.
  always_comb begin
    bus.req0_ready  = issue_ok && !gnt_id;
    bus.req1_ready  = issue_ok && gnt_id;
    bus.mul_stall   = stall;
    bus.mul_opA     = '0;
    bus.mul_opB     = '0;
    if (accept) begin
      bus.mul_opA = gnt_id ? bus.req1_a : bus.req0_a;
      bus.mul_opB = gnt_id ? bus.req1_b : bus.req0_b;
    end
    bus.rsp0_valid  = rst_n && !flush && s2.valid && !s2.id;
    bus.rsp1_valid  = rst_n && !flush && s2.valid && s2.id;
    bus.rsp0_result = bus.mul_result;
    bus.rsp1_result = bus.mul_result;
    busy            = s1.valid || s2.valid;
  end

  // Tag pipe advances in lockstep with the multiplier; reset/flush drop all.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let s2 capture the old s1 in the same edge.
    if (!rst_n || flush) begin
      // NOTE: only the valids need clearing; ids are don't-care while invalid.
      s1.valid <= 1'b0;
      s2.valid <= 1'b0;
    end else if (!stall) begin
      s1 <= '{valid: accept, id: gnt_id};
      s2 <= s1;
    end
  end

  // Round-robin pointer remembers the last accepted requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= gnt_id;
    end
  end

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mul_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  mul_arb_if bus ();

  mul_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural 2-stage multiplier, frozen by mul_stall.
  logic [31:0] m1, m2;
  always @(posedge clk) begin
    if (!bus.mul_stall) begin
      m1 <= bus.mul_opA * bus.mul_opB;
      m2 <= m1;
    end
  end
  assign bus.mul_result = m2;

  // Reference model: products in flight ([0] newest, [1] at the output).
  bit          mv[2];
  bit          mid[2];
  logic [31:0] mp[2];
  bit          mlast = 1'b1;

  int checks = 0;
  int failures = 0;

  // Snapshot of the last sampled cycle for directed checks.
  logic        s_r0v, s_r1v, s_stall, s_rdy0, s_rdy1, s_busy;
  logic [31:0] s_r0res, s_r1res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cyc(input bit v0, input bit v1,
                     input logic [31:0] a0, input logic [31:0] b0,
                     input logic [31:0] a1, input logic [31:0] b1,
                     input bit r0, input bit r1, input bit fl, input bit rn);
    bit stall, gnt, any, ok, acc, rv0, rv1;
    rst_n = rn;
    flush = fl;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = r0; bus.rsp1_ready = r1;

    stall = rn && !fl && mv[1] && !(mid[1] ? r1 : r0);
    any   = v0 || v1;
    gnt   = (v0 && v1) ? !mlast : v1;
    ok    = rn && !fl && !stall;
    acc   = ok && any;
    rv0   = rn && !fl && mv[1] && !mid[1];
    rv1   = rn && !fl && mv[1] && mid[1];

    @(negedge clk);
    check("mul_stall", bus.mul_stall, stall);
    if (any || !ok) begin
      check("req0_ready", bus.req0_ready, acc && !gnt);
      check("req1_ready", bus.req1_ready, acc && gnt);
    end
    check("rsp0_valid", bus.rsp0_valid, rv0);
    check("rsp1_valid", bus.rsp1_valid, rv1);
    if (rv0) check("rsp0_result", bus.rsp0_result, mp[1]);
    if (rv1) check("rsp1_result", bus.rsp1_result, mp[1]);
    check("mul_opA", bus.mul_opA, acc ? (gnt ? a1 : a0) : 32'h0);
    check("mul_opB", bus.mul_opB, acc ? (gnt ? b1 : b0) : 32'h0);
    if (rn) check("busy", busy, mv[0] || mv[1]);
    s_r0v = bus.rsp0_valid;   s_r1v = bus.rsp1_valid;
    s_r0res = bus.rsp0_result; s_r1res = bus.rsp1_result;
    s_stall = bus.mul_stall;  s_rdy0 = bus.req0_ready; s_rdy1 = bus.req1_ready;
    s_busy = busy;

    @(posedge clk);
    if (!rn) begin
      mv[0] = 1'b0; mv[1] = 1'b0; mlast = 1'b1;
    end else if (fl) begin
      mv[0] = 1'b0; mv[1] = 1'b0;
    end else begin
      if (!stall) begin
        mv[1] = mv[0]; mid[1] = mid[0]; mp[1] = mp[0];
        mv[0] = acc;   mid[0] = gnt;    mp[0] = gnt ? a1 * b1 : a0 * b0;
      end
      if (acc) mlast = gnt;
    end
    #1;
  endtask

  task automatic idle(input bit r0, input bit r1);
    cyc(0, 0, 0, 0, 0, 0, r0, r1, 0, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endtask

  initial begin
    do_reset(2);
    idle(1, 1);
    check("reset_busy", s_busy, 0);
    check("reset_stall", s_stall, 0);

    // Single multiply: 7*6 returns on port 0 two cycles later.
    cyc(1, 0, 7, 6, 0, 0, 1, 1, 0, 1);
    check("single_accept", s_rdy0, 1);
    idle(1, 1);
    idle(1, 1);
    check("single_rsp0_valid", s_r0v, 1);
    check("single_rsp0_result", s_r0res, 42);
    check("single_rsp1_valid", s_r1v, 0);
    idle(1, 1);

    // Tie: grants alternate 0,1,0,1 from reset.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, i, 2, i, 2, 1, 1, 0, 1);
      check("tie_grant0", s_rdy0, (i % 2) == 0);
      check("tie_grant1", s_rdy1, (i % 2) == 1);
    end
    idle(1, 1);
    idle(1, 1);

    // Wrap-around product.
    cyc(1, 0, 32'hFFFF_FFFF, 32'h2, 0, 0, 1, 1, 0, 1);
    idle(1, 1);
    idle(1, 1);
    check("wrap_result", s_r0res, 32'hFFFF_FFFE);

    // Backpressure on port 1 with 3*5 then 4*5 behind it.
    cyc(0, 1, 0, 0, 3, 5, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 4, 5, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 9, 9, 0, 0, 1, 0, 0, 1);
      check("bp_stall", s_stall, 1);
      check("bp_req0_ready", s_rdy0, 0);
      check("bp_rsp1_result", s_r1res, 15);
    end
    idle(1, 1);
    check("bp_release_valid", s_r1v, 1);
    check("bp_release_result", s_r1res, 15);
    idle(1, 1);
    check("bp_follow_valid", s_r1v, 1);
    check("bp_follow_result", s_r1res, 20);
    idle(1, 1);

    // Flush with two products in flight.
    cyc(1, 0, 2, 3, 0, 0, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 4, 4, 1, 1, 0, 1);
    cyc(1, 1, 5, 5, 6, 6, 1, 1, 1, 1);
    check("flush_rsp0", s_r0v, 0);
    check("flush_ready0", s_rdy0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      if (i == 0) check("flush_busy", s_busy, 0);
      check("flush_no_rsp0", s_r0v, 0);
      check("flush_no_rsp1", s_r1v, 0);
    end

    // Reset with one product in flight.
    cyc(1, 0, 9, 9, 0, 0, 1, 1, 0, 1);
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      if (i == 0) check("rst_busy", s_busy, 0);
      check("rst_no_rsp0", s_r0v, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom % 2, $urandom % 2, $urandom, $urandom, $urandom, $urandom,
          ($urandom % 4) != 0, ($urandom % 4) != 0,
          ($urandom % 50) == 0, ($urandom % 200) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: flush  in  1  discard all in-flight multiplies.
REQ-004 SHALL have ports: req0_valid  in  1 / req0_ready  out  1 / req0_a  in  32 / req0_b  in  32  requester 0 operands.
REQ-005 SHALL have ports: req1_valid  in  1 / req1_ready  out  1 / req1_a  in  32 / req1_b  in  32  requester 1 operands.
REQ-006 SHALL have ports: rsp0_valid  out  1 / rsp0_ready  in  1 / rsp0_result  out  32  requester 0 product (low 32 bits).
REQ-007 SHALL have ports: rsp1_valid  out  1 / rsp1_ready  in  1 / rsp1_result  out  32  requester 1 product (low 32 bits).
REQ-008 SHALL have ports: mul_stall  out  1 / mul_opA  out  32 / mul_opB  out  32 / mul_result  in  32  to a shared 2-stage multiplier.
REQ-009 SHALL have ports: busy  out  1  any multiply in flight.

Function
REQ-010 Shared multiplier: operands presented in cycle t with mul_stall=0 appear on mul_result after two non-stalled edges; mul_stall=1 freezes both multiplier stages.
REQ-011 SHALL track ownership in a 2-entry tag pipe (valid + requester id) that advances exactly when mul_stall=0, mirroring multiplier stages 1 and 2.
REQ-012 Handshake: a request is accepted when reqN_valid & reqN_ready are both high on a rising edge; operands need not be held after acceptance.
REQ-013 reqN_ready SHALL be high only when mul_stall=0, flush=0, rst_n=1 and requester N holds the grant.
REQ-014 Arbitration: round-robin; with one requester valid it is granted; with both valid the one not granted last SHALL be granted; the pointer updates only on acceptance.
REQ-015 mul_opA/mul_opB SHALL carry the granted requester's operands in the cycle of acceptance, else 32'h0; stage-1 tag valid=0 for bubbles.
REQ-016 rspN_valid SHALL be high iff stage-2 tag valid=1 and tag id=N; rspN_result = mul_result; other response valid low.
REQ-017 mul_stall SHALL equal stage-2 tag valid & !rsp_ready of the owning requester; bubbles never cause a stall.
REQ-018 A response completes when rspN_valid & rspN_ready are high; back-to-back throughput one product per cycle, latency 2 cycles from acceptance to rsp_valid.
REQ-019 While stalled, rspN_valid and rspN_result SHALL remain stable until accepted.
REQ-020 flush=1 SHALL clear both tag valids on the next edge and force both req_ready and mul_stall low that cycle; results already in the multiplier are discarded; flush wins over simultaneous request.
REQ-021 busy SHALL be OR of both tag valids.
REQ-022 Product arithmetic is unsigned modulo 2^32 (low word); no overflow indication.

Reset
REQ-023 On rst_n=0 at an edge: tag valids=0, round-robin pointer set so requester 0 wins the next tie.
REQ-024 During and after reset until first acceptance: all ready/valid outputs 0 during reset, mul_stall=0, mul_opA/opB=0, busy=0.
REQ-025 Reset mid-operation SHALL discard in-flight multiplies without emitting responses.

Verification
REQ-026 Single: req0 a=7 b=6 accepted cycle t, rsp0_ready=1 -> rsp0_valid=1, rsp0_result=42 at t+2; rsp1_valid stays 0.
REQ-027 Tie: both valid every cycle, a=i, b=2 -> grants alternate 0,1,0,1 starting with 0 after reset; results return in order to correct port.
REQ-028 Backpressure: product 3*5 for req1 reaches stage 2 with rsp1_ready=0 for 3 cycles -> mul_stall=1, req_ready=0, rsp1_result=15 held, then accepted; following product follows next cycle.
REQ-029 Flush: two multiplies in flight, flush pulsed -> next cycle busy=0, no rsp_valid ever produced for them.
REQ-030 Wrap: 32'hFFFFFFFF * 32'h2 -> result 32'hFFFFFFFE; reset asserted with one multiply in flight -> no response, busy=0.
